// File: rtl/axistream_in_if.sv
// rtl/axistream_in_if.sv - stream-in, stream-forward and CSR bus bundle for axistream_in
interface axistream_in_if #(
    parameter int DATA_W  = 32,
    parameter int TDATA_W = 32
);
    logic [TDATA_W-1:0]  axis_tdata;
    logic                axis_tvalid;
    logic                axis_tready;
    logic                axis_tlast;

    logic [TDATA_W-1:0]  sys_tdata;
    logic                sys_tvalid;
    logic                sys_tready;

    logic                csr_valid;
    logic [3:0]          csr_addr;
    logic [DATA_W-1:0]   csr_wdata;
    logic [DATA_W/8-1:0] csr_wstrb;
    logic                csr_rvalid;
    logic [DATA_W-1:0]   csr_rdata;
    logic                csr_rready;
    logic                csr_ready;

    modport master (
        output axis_tdata, axis_tvalid, axis_tlast, sys_tready,
        output csr_valid, csr_addr, csr_wdata, csr_wstrb, csr_rready,
        input  axis_tready, sys_tdata, sys_tvalid, csr_rvalid, csr_rdata, csr_ready
    );

    modport slave (
        input  axis_tdata, axis_tvalid, axis_tlast, sys_tready,
        input  csr_valid, csr_addr, csr_wdata, csr_wstrb, csr_rready,
        output axis_tready, sys_tdata, sys_tvalid, csr_rvalid, csr_rdata, csr_ready
    );
endinterface

// File: rtl/axistream_in.sv
// rtl/axistream_in.sv - stream sink FIFO drained by CSR reads or forwarded to a system stream
module axistream_in #(
    parameter int DATA_W      = 32,
    parameter int TDATA_W     = 32,
    parameter int FIFO_ADDR_W = 10
) (
    input  logic           clk,
    input  logic           cke,
    input  logic           rst_n,
    output logic           interrupt,
    axistream_in_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE = {{(FIFO_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_W:0]   LVL_ONE = {{FIFO_ADDR_W{1'b0}}, 1'b1};

    localparam logic [3:0] A_SOFT_RESET = 4'd0;
    localparam logic [3:0] A_ENABLE     = 4'd1;
    localparam logic [3:0] A_DATA       = 4'd2;
    localparam logic [3:0] A_MODE       = 4'd3;
    localparam logic [3:0] A_NWORDS     = 4'd4;
    localparam logic [3:0] A_TLAST      = 4'd5;
    localparam logic [3:0] A_FULL       = 4'd6;
    localparam logic [3:0] A_EMPTY      = 4'd7;
    localparam logic [3:0] A_THRESHOLD  = 4'd8;
    localparam logic [3:0] A_LEVEL      = 4'd9;

    logic [TDATA_W-1:0]     mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_W:0]   level, threshold;
    logic                   soft_reset, enable, mode, tlast_seen;
    logic [31:0]            nwords;
    logic                   rvalid;
    logic [DATA_W-1:0]      rdata, rd_mux;

    logic full, empty, accept, wr_req, rd_req, push, pop_csr, pop_sys, pop;
    logic [TDATA_W-1:0] head;
    logic unused_wdata;

    // Level never exceeds DEPTH, so its top bit alone marks full.
    assign full   = level[FIFO_ADDR_W];
    assign empty  = (level == '0);
    assign head   = mem[rd_ptr];

    assign accept  = cke & bus.csr_valid & ~rvalid;
    assign wr_req  = accept & (|bus.csr_wstrb);
    assign rd_req  = accept & ~(|bus.csr_wstrb);
    assign push    = cke & bus.axis_tvalid & bus.axis_tready;
    assign pop_csr = rd_req & (bus.csr_addr == A_DATA) & ~mode & ~empty;
    assign pop_sys = cke & bus.sys_tvalid & bus.sys_tready;
    assign pop     = pop_csr | pop_sys;

    assign bus.axis_tready = enable & ~soft_reset & ~full;
    assign bus.sys_tvalid  = mode & ~empty;
    assign bus.sys_tdata   = bus.sys_tvalid ? head : '0;
    assign bus.csr_ready   = ~rvalid;
    assign bus.csr_rvalid  = rvalid;
    assign bus.csr_rdata   = rdata;

    assign unused_wdata = ^bus.csr_wdata[DATA_W-1:FIFO_ADDR_W+1];

    always_comb begin
        rd_mux = '0;
        case (bus.csr_addr)
            A_DATA:   if (!mode && !empty) rd_mux = DATA_W'(head);
            A_NWORDS: rd_mux = DATA_W'(nwords);
            A_TLAST:  rd_mux[0] = tlast_seen;
            A_FULL:   rd_mux[0] = full;
            A_EMPTY:  rd_mux[0] = empty;
            A_LEVEL:  rd_mux = DATA_W'(level);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.axis_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soft_reset <= 1'b0;
            enable     <= 1'b0;
            mode       <= 1'b0;
            threshold  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            nwords     <= '0;
            tlast_seen <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            interrupt  <= 1'b0;
        end else if (cke) begin
            if (wr_req) begin
                case (bus.csr_addr)
                    A_SOFT_RESET: soft_reset <= bus.csr_wdata[0];
                    A_ENABLE:     enable     <= bus.csr_wdata[0];
                    A_MODE:       mode       <= bus.csr_wdata[0];
                    A_THRESHOLD:  threshold  <= bus.csr_wdata[FIFO_ADDR_W:0];
                    default:      ;
                endcase
            end

            // Response is captured at acceptance and held until the host takes it.
            if (rd_req) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
            end else if (rvalid && bus.csr_rready) begin
                rvalid <= 1'b0;
                rdata  <= '0;
            end

            if (soft_reset) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level      <= '0;
                nwords     <= '0;
                tlast_seen <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    nwords <= nwords + 32'd1;
                    if (bus.axis_tlast) tlast_seen <= 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + PTR_ONE;
                if (push && !pop)      level <= level + LVL_ONE;
                else if (pop && !push) level <= level - LVL_ONE;
            end

            interrupt <= (level >= threshold) && (threshold != '0);
        end
    end
endmodule

// File: tb/tb_axistream_in.sv
// tb/tb_axistream_in.sv - self-checking bench for axistream_in against a queue model
module tb_axistream_in;
    logic clk = 1'b0;
    logic cke;
    logic rst_n;
    logic interrupt;
    int   checks = 0;
    int   errors = 0;

    axistream_in_if #(.DATA_W(32), .TDATA_W(32)) bus();

    axistream_in #(.DATA_W(32), .TDATA_W(32), .FIFO_ADDR_W(10)) dut (
        .clk       (clk),
        .cke       (cke),
        .rst_n     (rst_n),
        .interrupt (interrupt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] A_SOFT_RESET = 4'd0, A_ENABLE = 4'd1, A_DATA = 4'd2, A_MODE = 4'd3,
                           A_NWORDS = 4'd4, A_TLAST = 4'd5, A_FULL = 4'd6, A_EMPTY = 4'd7,
                           A_THRESHOLD = 4'd8, A_LEVEL = 4'd9;
    localparam int DEPTH = 1024;

    logic [31:0] q[$];
    int unsigned m_nwords = 0;
    bit          m_tlast  = 0;
    bit          m_mode   = 0;
    int          m_thr    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_irq();
        return (m_thr != 0) && (q.size() >= m_thr);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.csr_valid = 1'b1; bus.csr_addr = a; bus.csr_wdata = d; bus.csr_wstrb = 4'hF;
        while (!bus.csr_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.csr_ready) check("write_ready_timeout", bus.csr_ready, 1'b1);
        @(posedge clk); #1;
        bus.csr_valid = 1'b0; bus.csr_wstrb = 4'h0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.csr_valid = 1'b1; bus.csr_addr = a; bus.csr_wstrb = 4'h0; bus.csr_rready = 1'b1;
        while (!bus.csr_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.csr_valid = 1'b0;
        n = 0;
        while (!bus.csr_rvalid && n < 20) begin tick(); n++; end
        if (!bus.csr_rvalid) check("rvalid_timeout", bus.csr_rvalid, 1'b1);
        d = bus.csr_rdata;
        tick();
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(a, d);
        check(tag, d, exp);
    endtask

    // Model: a DATA read pops only in CSR-drain mode with data present.
    task automatic read_data(input string tag);
        logic [31:0] exp;
        exp = (!m_mode && q.size() > 0) ? q.pop_front() : 32'h0;
        read_check(tag, A_DATA, exp);
    endtask

    task automatic push_beat(input logic [31:0] d, input bit last);
        int n = 0;
        @(negedge clk);
        bus.axis_tdata = d; bus.axis_tlast = last; bus.axis_tvalid = 1'b1;
        while (!bus.axis_tready && n < 50) begin @(negedge clk); n++; end
        if (!bus.axis_tready) begin
            check("push_timeout", bus.axis_tready, 1'b1);
            bus.axis_tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.axis_tvalid = 1'b0; bus.axis_tlast = 1'b0;
        q.push_back(d);
        m_nwords++;
        if (last) m_tlast = 1'b1;
    endtask

    task automatic soft_reset_pulse();
        csr_write(A_SOFT_RESET, 32'd1);
        check("tready_in_soft_reset", bus.axis_tready, 1'b0);
        csr_write(A_SOFT_RESET, 32'd0);
        q.delete();
        m_nwords = 0;
        m_tlast  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, exp;

        cke = 1'b1; rst_n = 1'b0;
        bus.axis_tdata = '0; bus.axis_tvalid = 1'b0; bus.axis_tlast = 1'b0; bus.sys_tready = 1'b0;
        bus.csr_valid = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.csr_wstrb = '0;
        bus.csr_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", bus.axis_tready, 1'b0);
        check("rst_sys_tvalid", bus.sys_tvalid, 1'b0);
        check("rst_sys_tdata", bus.sys_tdata, 32'h0);
        check("rst_rvalid", bus.csr_rvalid, 1'b0);
        check("rst_rdata", bus.csr_rdata, 32'h0);
        check("rst_interrupt", interrupt, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        read_check("rst_empty", A_EMPTY, 32'd1);
        read_check("rst_level", A_LEVEL, 32'd0);
        read_check("rst_nwords", A_NWORDS, 32'd0);
        read_check("rst_full", A_FULL, 32'd0);
        read_check("rst_tlast", A_TLAST, 32'd0);
        check("tready_disabled", bus.axis_tready, 1'b0);

        csr_write(A_SOFT_RESET, 32'd0);
        csr_write(A_MODE, 32'd0);
        csr_write(A_ENABLE, 32'd1);
        check("tready_enabled", bus.axis_tready, 1'b1);

        for (int i = 0; i < 256; i++) push_beat($urandom, i == 255);
        read_check("level_256", A_LEVEL, 32'(q.size()));
        for (int i = 0; i < 256; i++) read_data("drain_data");
        read_check("nwords_256", A_NWORDS, m_nwords);
        read_check("tlast_set", A_TLAST, 32'(m_tlast));
        read_check("empty_after_drain", A_EMPTY, 32'd1);
        read_data("data_when_empty");

        for (int i = 0; i < DEPTH; i++) push_beat($urandom, 1'b0);
        check("tready_full", bus.axis_tready, 1'b0);
        read_check("full_flag", A_FULL, 32'(q.size() == DEPTH));
        read_check("level_full", A_LEVEL, 32'(q.size()));
        read_data("data_from_full");
        check("tready_after_pop", bus.axis_tready, 1'b1);
        read_check("level_after_pop", A_LEVEL, 32'(q.size()));
        read_check("nwords_wrapped_ptr", A_NWORDS, m_nwords);

        soft_reset_pulse();
        read_check("sr1_level", A_LEVEL, 32'd0);
        read_check("sr1_nwords", A_NWORDS, 32'd0);
        read_check("sr1_tlast", A_TLAST, 32'd0);
        read_check("sr1_empty", A_EMPTY, 32'd1);
        check("sr1_enable_kept", bus.axis_tready, 1'b1);

        csr_write(A_THRESHOLD, 32'd4);
        m_thr = 4;
        for (int i = 0; i < 3; i++) push_beat($urandom, 1'b0);
        tick();
        check("irq_below", interrupt, exp_irq());
        push_beat($urandom, 1'b0);
        tick();
        check("irq_at_threshold", interrupt, exp_irq());
        read_data("irq_pop_data");
        tick();
        check("irq_after_pop", interrupt, exp_irq());
        for (int i = 0; i < 3; i++) read_data("irq_drain");

        @(negedge clk); bus.sys_tready = 1'b1;
        csr_write(A_MODE, 32'd1);
        m_mode = 1'b1;
        push_beat($urandom, 1'b0);
        check("fwd_tvalid", bus.sys_tvalid, 1'b1);
        check("fwd_tdata", bus.sys_tdata, q[0]);
        tick();
        void'(q.pop_front());
        check("fwd_tvalid_drop", bus.sys_tvalid, 1'b0);
        read_data("mode1_data_zero");

        @(negedge clk); bus.sys_tready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat($urandom, 1'b0);
        check("fwd_hold_tvalid", bus.sys_tvalid, 1'b1);
        check("fwd_hold_tdata", bus.sys_tdata, q[0]);
        read_data("mode1_nopop");
        read_check("mode1_level", A_LEVEL, 32'(q.size()));
        @(negedge clk); bus.sys_tready = 1'b1;
        repeat (3) begin
            check("fwd_burst_tvalid", bus.sys_tvalid, 1'b1);
            check("fwd_burst_tdata", bus.sys_tdata, q[0]);
            @(posedge clk);
            void'(q.pop_front());
            @(negedge clk);
        end
        check("fwd_drained", bus.sys_tvalid, 1'b0);
        bus.sys_tready = 1'b0;
        csr_write(A_MODE, 32'd0);
        m_mode = 1'b0;

        for (int i = 0; i < 5; i++) push_beat($urandom, i == 2);
        read_check("sr2_pre_tlast", A_TLAST, 32'(m_tlast));
        soft_reset_pulse();
        read_check("sr2_level", A_LEVEL, 32'd0);
        read_check("sr2_nwords", A_NWORDS, 32'd0);
        read_check("sr2_tlast", A_TLAST, 32'd0);

        push_beat($urandom, 1'b0);
        exp = q.pop_front();
        @(negedge clk);
        bus.csr_valid = 1'b1; bus.csr_addr = A_DATA; bus.csr_wstrb = 4'h0; bus.csr_rready = 1'b0;
        tick();
        bus.csr_valid = 1'b0;
        repeat (3) begin
            check("held_rvalid", bus.csr_rvalid, 1'b1);
            check("held_rdata", bus.csr_rdata, exp);
            check("held_ready_low", bus.csr_ready, 1'b0);
            tick();
        end
        @(negedge clk); bus.csr_rready = 1'b1;
        tick();
        check("released_rvalid", bus.csr_rvalid, 1'b0);
        check("released_ready", bus.csr_ready, 1'b1);

        d = $urandom;
        @(negedge clk);
        cke = 1'b0; bus.axis_tdata = d; bus.axis_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        bus.axis_tvalid = 1'b0; cke = 1'b1;
        read_check("cke_level", A_LEVEL, 32'(q.size()));
        read_check("cke_nwords", A_NWORDS, m_nwords);
        read_check("unmapped_read", 4'hF, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axistream_in.md
Name: axistream_in

Overview:
- AXI-Stream sink peripheral. Accepts beats on an AXI-Stream subordinate port and buffers them in an internal FIFO.
- The CPU drains the FIFO through an IOb-native CSR bus. Alternatively, the FIFO output is forwarded to a system-side AXI-Stream manager port.
- Sits on the peripheral bus; typically fed by the matching axistream_out block.

Parameters:
- DATA_W, 32: CSR bus data width.
- TDATA_W, 32: stream data width. Must be ≤ DATA_W; zero-extended on DATA reads.
- FIFO_ADDR_W, 10: FIFO depth is 2^FIFO_ADDR_W words.

Ports:
- clk_i  in  1  single clock for the bus, stream and FIFO.
- cke_i  in  1  clock enable; all state holds when 0.
- arst_n_i  in  1  asynchronous, active-low reset.
- interrupt_o  out  1  FIFO level ≥ FIFO_THRESHOLD.
- axis_tdata_i  in  TDATA_W  stream data.
- axis_tvalid_i  in  1  stream valid.
- axis_tready_o  out  1  stream ready.
- axis_tlast_i  in  1  last beat of packet.
- sys_tdata_o  out  TDATA_W  forwarded FIFO data.
- sys_tvalid_o  out  1  forwarded valid.
- sys_tready_i  in  1  forwarded ready.
- iob_csrs_iob_valid_i  in  1  request valid.
- iob_csrs_iob_addr_i  in  4  word address (byte address >> 2).
- iob_csrs_iob_wdata_i  in  DATA_W  write data.
- iob_csrs_iob_wstrb_i  in  DATA_W/8  write strobes; nonzero = write, zero = read.
- iob_csrs_iob_rvalid_o  out  1  read data valid.
- iob_csrs_iob_rdata_o  out  DATA_W  read data.
- iob_csrs_iob_rready_i  in  1  read data accepted.
- iob_csrs_iob_ready_o  out  1  request accepted.

Behaviour:
- Reset: all CSRs 0, FIFO empty, all outputs 0.
- CSR map (byte address / width / access):
  - 0x00 SOFT_RESET, 1 bit, W.
  - 0x04 ENABLE, 1 bit, W.
  - 0x08 DATA, TDATA_W, R, pops FIFO.
  - 0x0C MODE, 1 bit, W.
  - 0x10 NWORDS, 32 bits, R.
  - 0x14 TLAST_DETECTED, 1 bit, R.
  - 0x18 FIFO_FULL, 1 bit, R.
  - 0x1C FIFO_EMPTY, 1 bit, R.
  - 0x20 FIFO_THRESHOLD, FIFO_ADDR_W+1 bits, W.
  - 0x24 FIFO_LEVEL, FIFO_ADDR_W+1 bits, R.
  - Unmapped reads return 0; unmapped writes are ignored.
- Bus handshake:
  - A request is accepted on a rising edge with valid_i & ready_o.
  - Writes complete on acceptance; no response.
  - On a read, rvalid_o rises the cycle after acceptance. rdata_o and rvalid_o are held until an edge with rvalid_o & rready_i.
  - ready_o is 1 except while a read response is pending.
- SOFT_RESET:
  - While 1, empties the FIFO and clears NWORDS and TLAST_DETECTED.
  - Forces axis_tready_o low.
  - ENABLE, MODE and FIFO_THRESHOLD keep their values.
- Stream input:
  - axis_tready_o = ENABLE & ~SOFT_RESET & ~fifo_full.
  - A beat is pushed on tvalid & tready; this increments NWORDS (wraps at 2^32).
  - A beat with tlast sets TLAST_DETECTED (sticky until soft reset). Reception continues after tlast.
- MODE 0 (CSR drain):
  - A DATA read returns the FIFO head and pops it. FIFO data is registered-ahead so the value is valid in the rvalid cycle.
  - A DATA read while empty returns 0 and does not pop.
  - sys_tvalid_o = 0.
- MODE 1 (system forward):
  - sys_tvalid_o = ~fifo_empty; sys_tdata_o = head.
  - The FIFO pops on sys_tvalid_o & sys_tready_i.
  - DATA reads return 0 and do not pop.
- Simultaneous push and pop: level unchanged. Push when full never happens because tready is low.
- FIFO_LEVEL ranges 0..2^FIFO_ADDR_W; FIFO_FULL = level == depth.
- interrupt_o = (level ≥ FIFO_THRESHOLD) & (FIFO_THRESHOLD ≠ 0), registered.
- cke_i = 0 freezes all registers.

Test Plan:
- Reset, then read FIFO_EMPTY=1, FIFO_LEVEL=0, NWORDS=0; axis_tready_o=0 (ENABLE=0).
- Write SOFT_RESET=0, MODE=0, ENABLE=1. Stream words 0..255 with tlast on word 255. Read DATA 256 times → values 0..255 in order. Then NWORDS=256, TLAST_DETECTED=1, FIFO_EMPTY=1.
- Fill 1024 words with no reads → FIFO_FULL=1, axis_tready_o=0, FIFO_LEVEL=1024. One DATA read → tready returns to 1.
- FIFO_THRESHOLD=4, push 3 words → interrupt_o=0. Push a 4th → interrupt_o=1. Read one → interrupt_o=0.
- MODE=1 with sys_tready_i=1, push 0xA5 → sys_tvalid_o pulses with sys_tdata_o=0xA5; DATA read returns 0.
- With 5 words buffered, SOFT_RESET=1 then 0 → FIFO_LEVEL=0, NWORDS=0, TLAST_DETECTED=0. A read held with rready_i=0 for 3 cycles keeps rvalid_o=1 and rdata_o stable.
